alu_arbiter: RTL and testbench

Two-port arbiter that shares one combinational `alu` instance between two requesters, such as the execute stage and a secondary address/branch unit. Each requester issues operations over a valid/ready request channel. Each receives its registered result over its own valid/ready response channel. The block sits between the requesters and the ALU, owns the round-robin priority state, and stalls only the requester whose response slot is still occupied.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu.sv | 62 ++++++
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU and its two-port arbiter: operation codes,
//   default widths, and the request/response structs that carry one ALU
//   transaction.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_DATA_W  = 64;
  localparam int ALU_CTRL_W  = 5;
  localparam int ALU_SHAMT_W = $clog2(ALU_DATA_W);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 5'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 5'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 5'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 5'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADDW = 5'd10;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUBW = 5'd11;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLLW = 5'd12;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRLW = 5'd13;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRAW = 5'd14;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] control;
    logic [ALU_DATA_W-1:0] src_1;
    logic [ALU_DATA_W-1:0] src_2;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic                  lt;
    logic                  ltu;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Purely combinational RV64-style integer ALU.
//   i_req : operation code and two operands
//   o_rsp : result plus zero / signed-lt / unsigned-lt flags
//   The lt/ltu flags always come from the full-width operand compare. W-ops
//   work on the low 32 bits and sign-extend the 32-bit result. Undefined
//   codes give a result of 0 (so zero is set).
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  alu_req_t i_req,
  output alu_rsp_t o_rsp
);

  logic [ALU_DATA_W-1:0]  w_result;
  logic [31:0]            w_word;
  logic [ALU_SHAMT_W-1:0] w_shamt;
  logic [4:0]             w_shamt_w;
  logic                   w_lt;
  logic                   w_ltu;

  assign w_shamt   = i_req.src_2[ALU_SHAMT_W-1:0];
  assign w_shamt_w = i_req.src_2[4:0];
  assign w_lt      = $signed(i_req.src_1) < $signed(i_req.src_2);
  assign w_ltu     = i_req.src_1 < i_req.src_2;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_result = '0;
    w_word   = '0;
    unique case (i_req.control)
      ALU_ADD:  w_result = i_req.src_1 + i_req.src_2;
      ALU_SUB:  w_result = i_req.src_1 - i_req.src_2;
      ALU_AND:  w_result = i_req.src_1 & i_req.src_2;
      ALU_OR:   w_result = i_req.src_1 | i_req.src_2;
      ALU_XOR:  w_result = i_req.src_1 ^ i_req.src_2;
      ALU_SLL:  w_result = i_req.src_1 << w_shamt;
      ALU_SLT:  w_result = {{(ALU_DATA_W-1){1'b0}}, w_lt};
      ALU_SLTU: w_result = {{(ALU_DATA_W-1){1'b0}}, w_ltu};
      ALU_SRL:  w_result = i_req.src_1 >> w_shamt;
      ALU_SRA:  w_result = $unsigned($signed(i_req.src_1) >>> w_shamt);
      ALU_ADDW: w_word   = i_req.src_1[31:0] + i_req.src_2[31:0];
      ALU_SUBW: w_word   = i_req.src_1[31:0] - i_req.src_2[31:0];
      ALU_SLLW: w_word   = i_req.src_1[31:0] << w_shamt_w;
      ALU_SRLW: w_word   = i_req.src_1[31:0] >> w_shamt_w;
      ALU_SRAW: w_word   = $unsigned($signed(i_req.src_1[31:0]) >>> w_shamt_w);
      default:  w_result = '0;
    endcase
    // W-ops share one sign-extension point instead of one per case arm.
    if (i_req.control inside {ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW})
      w_result = {{(ALU_DATA_W-32){w_word[31]}}, w_word};
  end

  assign o_rsp.result = w_result;
  assign o_rsp.zero   = (w_result == '0);
  assign o_rsp.lt     = w_lt;
  assign o_rsp.ltu    = w_ltu;

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters with round-robin
//   priority and a one-entry registered response slot per requester.
//   i_clk, i_arst (async, active-low)
//   i_req_valid/o_req_ready, i_req_control, i_req_src_1, i_req_src_2 [1:0]
//   o_rsp_valid/i_rsp_ready, o_rsp_result, o_rsp_zero/lt/ltu          [1:0]
//   A requester is only stalled while its own slot is full and not being
//   drained; the other requester is unaffected.
//   DATA_WIDTH / CONTROL_WIDTH must match the alu_pkg widths.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CONTROL_WIDTH = 5
) (
  input  logic                             i_clk,
  input  logic                             i_arst,
  input  logic [1:0]                       i_req_valid,
  output logic [1:0]                       o_req_ready,
  input  logic [1:0][CONTROL_WIDTH-1:0]    i_req_control,
  input  logic [1:0][DATA_WIDTH-1:0]       i_req_src_1,
  input  logic [1:0][DATA_WIDTH-1:0]       i_req_src_2,
  output logic [1:0]                       o_rsp_valid,
  input  logic [1:0]                       i_rsp_ready,
  output logic [1:0][DATA_WIDTH-1:0]       o_rsp_result,
  output logic [1:0]                       o_rsp_zero,
  output logic [1:0]                       o_rsp_lt,
  output logic [1:0]                       o_rsp_ltu
);

  logic [1:0] r_rsp_valid;
  alu_rsp_t   r_slot [2];
  logic       r_prio;

  logic [1:0] w_free;
  logic [1:0] w_elig;
  logic [1:0] w_grant;
  logic       w_grant_any;
  logic       w_grant_idx;
  alu_req_t   w_alu_req;
  alu_rsp_t   w_alu_rsp;

  // A slot can take a new result if it is empty or being drained this cycle.
  // Eligibility is gated by reset so o_req_ready stays low while i_arst is low.
  assign w_free = ~r_rsp_valid | i_rsp_ready;
  assign w_elig = i_req_valid & w_free & {2{i_arst}};

  always_comb begin
    w_grant = w_elig;
    if (&w_elig)
      w_grant = r_prio ? 2'b10 : 2'b01;
  end

  assign w_grant_any = |w_grant;
  assign w_grant_idx = w_grant[1];
  assign o_req_ready = w_grant;

  assign w_alu_req.control = i_req_control[w_grant_idx];
  assign w_alu_req.src_1   = i_req_src_1[w_grant_idx];
  assign w_alu_req.src_2   = i_req_src_2[w_grant_idx];

  alu u_alu (
    .i_req (w_alu_req),
    .o_rsp (w_alu_rsp)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order of statements or blocks.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst)
      r_prio <= 1'b0;
    else if (w_grant_any)
      r_prio <= ~w_grant_idx;
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    // NOTE: the result payload is reset along with the valid bit because the
    // outputs must read as zero in reset, not just be marked invalid.
    always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
        r_rsp_valid[g] <= 1'b0;
        r_slot[g]      <= '0;
      end else if (w_grant[g]) begin
        r_rsp_valid[g] <= 1'b1;
        r_slot[g]      <= w_alu_rsp;
      end else if (i_rsp_ready[g]) begin
        r_rsp_valid[g] <= 1'b0;
      end
    end

    assign o_rsp_result[g] = r_slot[g].result;
    assign o_rsp_zero[g]   = r_slot[g].zero;
    assign o_rsp_lt[g]     = r_slot[g].lt;
    assign o_rsp_ltu[g]    = r_slot[g].ltu;
  end

  assign o_rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed, table-driven bench for alu_arbiter plus hand-written sequences
//   for arbitration, backpressure, streaming and mid-response reset.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 64;
  localparam int CW = 5;

  logic                  i_clk;
  logic                  i_arst;
  logic [1:0]            i_req_valid;
  logic [1:0]            o_req_ready;
  logic [1:0][CW-1:0]    i_req_control;
  logic [1:0][DW-1:0]    i_req_src_1;
  logic [1:0][DW-1:0]    i_req_src_2;
  logic [1:0]            o_rsp_valid;
  logic [1:0]            i_rsp_ready;
  logic [1:0][DW-1:0]    o_rsp_result;
  logic [1:0]            o_rsp_zero;
  logic [1:0]            o_rsp_lt;
  logic [1:0]            o_rsp_ltu;

  alu_arbiter #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) dut (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_control (i_req_control),
    .i_req_src_1   (i_req_src_1),
    .i_req_src_2   (i_req_src_2),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_result  (o_rsp_result),
    .o_rsp_zero    (o_rsp_zero),
    .o_rsp_lt      (o_rsp_lt),
    .o_rsp_ltu     (o_rsp_ltu)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [CW-1:0] c, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    i_req_control[r] = c;
    i_req_src_1[r]   = a;
    i_req_src_2[r]   = b;
  endtask

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          zero;
    logic          lt;
    logic          ltu;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  initial begin
    vecs[0]  = '{ALU_ADD,  64'd5,    64'd7,  64'd12,   1'b0, 1'b1, 1'b1};
    vecs[1]  = '{ALU_SUB,  64'd3,    64'd3,  64'd0,    1'b1, 1'b0, 1'b0};
    vecs[2]  = '{ALU_AND,  64'hF0,   64'h3C, 64'h30,   1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ALU_OR,   64'hF0,   64'h0F, 64'hFF,   1'b0, 1'b0, 1'b0};
    vecs[4]  = '{ALU_XOR,  64'hFF,   64'h0F, 64'hF0,   1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ALU_SLL,  64'd1,    64'd4,  64'd16,   1'b0, 1'b1, 1'b1};
    vecs[6]  = '{ALU_SLT,  '1,       64'd1,  64'd1,    1'b0, 1'b1, 1'b0};
    vecs[7]  = '{ALU_SLTU, '1,       64'd1,  64'd0,    1'b1, 1'b1, 1'b0};
    vecs[8]  = '{ALU_SRL,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{ALU_SRA,  64'h8000_0000_0000_0000, 64'd63, '1,    1'b0, 1'b1, 1'b0};
    vecs[10] = '{ALU_ADDW, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{ALU_SUBW, 64'd0,    64'd1,  '1,       1'b0, 1'b1, 1'b1};
    vecs[12] = '{ALU_SLLW, 64'd1,    64'd31, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{ALU_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{ALU_SRAW, 64'h8000_0000, 64'd31, '1,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{5'b11111, 64'd9,    64'd9,  64'd0,    1'b1, 1'b0, 1'b0};
  end

  initial begin
    i_arst      = 1'b0;
    i_req_valid = 2'b01;
    i_rsp_ready = 2'b00;
    drive(0, ALU_ADD, 64'd1, 64'd1);
    drive(1, ALU_ADD, 64'd1, 64'd1);

    // Reset state: no grant even with a request pending.
    #2;
    check("reset_ready", 64'(o_req_ready), 64'd0);
    check("reset_valid", 64'(o_rsp_valid), 64'd0);
    check("reset_result0", o_rsp_result[0], 64'd0);
    check("reset_flags", 64'({o_rsp_zero, o_rsp_lt, o_rsp_ltu}), 64'd0);
    tick();
    tick();
    i_arst      = 1'b1;
    i_req_valid = 2'b00;
    tick();

    // Simultaneous requests: r0 first (prio 0), then r1, prio back to 0.
    i_req_valid = 2'b11;
    drive(0, ALU_SUB, 64'd3, 64'd3);
    drive(1, ALU_SLTU, 64'd1, 64'd2);
    #1;
    check("sim_c0_ready", 64'(o_req_ready), 64'b01);
    tick();
    i_req_valid = 2'b10;
    check("sim_r0_valid", 64'(o_rsp_valid), 64'b01);
    check("sim_r0_result", o_rsp_result[0], 64'd0);
    check("sim_r0_zero", 64'(o_rsp_zero[0]), 64'd1);
    #1;
    check("sim_c1_ready", 64'(o_req_ready), 64'b10);
    tick();
    i_req_valid = 2'b00;
    check("sim_r1_valid", 64'(o_rsp_valid[1]), 64'd1);
    check("sim_r1_result", o_rsp_result[1], 64'd1);
    i_rsp_ready = 2'b11;
    tick();
    check("sim_drained", 64'(o_rsp_valid), 64'd0);
    i_req_valid = 2'b11;
    #1;
    check("sim_prio_back_0", 64'(o_req_ready), 64'b01);
    tick();
    i_req_valid = 2'b00;
    tick();
    i_rsp_ready = 2'b00;

    // Table-driven single-op vectors on requester 0.
    for (int i = 0; i < NVEC; i++) begin
      i_req_valid = 2'b01;
      drive(0, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(o_req_ready[0]), 64'd1);
      tick();
      i_req_valid = 2'b00;
      check($sformatf("vec%0d_valid", i), 64'(o_rsp_valid[0]), 64'd1);
      check($sformatf("vec%0d_result", i), o_rsp_result[0], vecs[i].res);
      check($sformatf("vec%0d_flags", i),
            64'({o_rsp_zero[0], o_rsp_lt[0], o_rsp_ltu[0]}),
            64'({vecs[i].zero, vecs[i].lt, vecs[i].ltu}));
      i_rsp_ready = 2'b01;
      tick();
      check($sformatf("vec%0d_drain", i), 64'(o_rsp_valid[0]), 64'd0);
      i_rsp_ready = 2'b00;
    end

    // Backpressure isolation: r0 slot full and not drained; r1 keeps flowing.
    i_req_valid = 2'b01;
    drive(0, ALU_ADD, 64'd40, 64'd2);
    tick();
    drive(0, ALU_ADD, 64'd100, 64'd100);
    i_req_valid = 2'b11;
    i_rsp_ready = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      drive(1, ALU_ADD, 64'(k), 64'(k));
      #1;
      check($sformatf("bp%0d_ready", k), 64'(o_req_ready), 64'b10);
      tick();
      check($sformatf("bp%0d_r0_hold", k), o_rsp_result[0], 64'd42);
      check($sformatf("bp%0d_r0_valid", k), 64'(o_rsp_valid[0]), 64'd1);
      check($sformatf("bp%0d_r1_result", k), o_rsp_result[1], 64'(2 * k));
    end
    i_req_valid = 2'b00;
    i_rsp_ready = 2'b11;
    tick();
    check("bp_drained", 64'(o_rsp_valid), 64'd0);

    // Streaming: three back-to-back ADDs on r0 with drain held high.
    i_rsp_ready = 2'b01;
    i_req_valid = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      drive(0, ALU_ADD, 64'(k), 64'(k));
      #1;
      check($sformatf("st%0d_ready", k), 64'(o_req_ready[0]), 64'd1);
      tick();
      check($sformatf("st%0d_valid", k), 64'(o_rsp_valid[0]), 64'd1);
      check($sformatf("st%0d_result", k), o_rsp_result[0], 64'(2 * k));
    end
    i_req_valid = 2'b00;
    tick();
    check("st_end_valid", 64'(o_rsp_valid[0]), 64'd0);

    // Reset mid-response: fill both slots, then reset between edges.
    i_rsp_ready = 2'b00;
    i_req_valid = 2'b11;
    drive(0, ALU_ADD, 64'd10, 64'd1);
    drive(1, ALU_ADD, 64'd20, 64'd2);
    tick();
    tick();
    i_req_valid = 2'b00;
    check("rst_pre_valid", 64'(o_rsp_valid), 64'b11);
    check("rst_pre_result1", o_rsp_result[1], 64'd22);
    #2;
    i_arst = 1'b0;
    #1;
    check("rst_async_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_async_result", o_rsp_result[0] | o_rsp_result[1], 64'd0);
    tick();
    i_arst      = 1'b1;
    i_req_valid = 2'b11;
    #1;
    check("rst_after_prio", 64'(o_req_ready), 64'b01);
    tick();
    i_req_valid = 2'b00;
    check("rst_after_valid", 64'(o_rsp_valid), 64'b01);
    check("rst_after_result", o_rsp_result[0], 64'd11);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
